dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's data-memory interface.
- Accepts one load/store request at a time from the CPU over a req/ready handshake.
- Translates the CPU data address (segment base 0x10010000) into a word index into a synchronous-read word array.
- Supports byte/half/word accesses with sign/zero extension on loads and read-modify-write merging on sub-word stores. Flags misaligned or out-of-range accesses.

Parameters:
- BASE_ADDR, 32'h10010000, CPU address mapped to word 0 of the array.
- ADDR_WIDTH, 11, word-index width; array depth = 2**ADDR_WIDTH words (default 8 KiB, byte range 0x10010000–0x10011FFF).

Ports:
- clk_in  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  CPU byte address.
- wdata  input  32  store data; the low byte/half is used for sub-word stores.
- rdata  output  32  load result.
- ready  output  1  one-cycle completion pulse.
- err  output  1  qualifies ready; 1 = access rejected.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rdata=0, ready=0, err=0, busy=0.
  - Array contents are not reset.
- States: IDLE, RD, WR, RESP. All outputs are registered.
- IDLE, req=1 at edge E: capture we/size/sext/wdata, and compute off = addr - BASE_ADDR (32-bit unsigned wrap).
  - Error conditions: off >= 4*2**ADDR_WIDTH; size==3; half access with off[0]=1; word access with off[1:0]!=0.
  - Error -> RESP with err=1. No array access.
  - Load -> RD.
  - Word store -> WR.
  - Sub-word store -> RD.
- RD: array word at off[ADDR_WIDTH+1:2] is registered.
  - Load -> RESP. rdata = extracted lane, extended per sext.
  - Store -> WR.
- WR: array write occurs on the edge leaving WR, then -> RESP.
  - Word store writes wdata.
  - Sub-word store writes the read word with the lane replaced.
- RESP: ready=1 and busy=1 for exactly one cycle, then -> IDLE. req is ignored here; a held req is accepted on the next IDLE edge.
- Handshake latency, counted from accept edge E to the edge where ready rises: error 1, load 2, word store 2, sub-word store 3.
- Lane mapping is little-endian:
  - byte lane = off[1:0];
  - half lane = off[1] (bits 15:0 or 31:16).
- Extension: byte ext from bit 7, half from bit 15; sext=0 zero-fills.
- rdata update rules:
  - Updated only on a successful load entering RESP.
  - Cleared to 0 on an error response.
  - Unchanged by stores.
- err is valid only while ready=1. It is 0 otherwise.
- Inputs other than req are don't-care outside the accept edge; the captured copies are used.
- Reset mid-operation aborts to IDLE.
  - An in-flight store whose WR-exit edge has not occurred leaves memory unchanged (no partial write).
  - A write performed on an earlier edge persists.
- Out-of-range and wrap cases: addresses below BASE_ADDR wrap to a huge off and are reported as errors.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state encodings;
  - the default data-segment base 32'h10010000, shared with the CPU/top address translation.
- One combinational sub-module, dmem_lane:
  - load path: extract + sign/zero-extend;
  - store path: lane merge;
  - inputs word, off[1:0], size, sext, wdata.
- Array, FSM and error checks stay in dmem_responder.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x10010004, then lw @0x10010004 -> each ready arrives 2 edges after accept, err=0, rdata=0xDEADBEEF.
- sb wdata=0x00000080 @0x10010005 (ready at +3), then:
  - lb sext=1 -> 0xFFFFFF80;
  - lbu -> 0x00000080;
  - lw @0x10010004 -> 0xDEAD80EF.
- sh 0x8001 @0x10010006, then:
  - lw @0x10010004 -> 0x800180EF;
  - lh sext=1 @0x10010006 -> 0xFFFF8001;
  - lhu -> 0x00008001.
- Error accesses, each giving ready at +1, err=1, rdata=0, memory unchanged (verified by later lw):
  - lw @0x10010002;
  - lh @0x10010001;
  - size=3;
  - lw @0x10012000;
  - lw @0x1000FFFC.
- Boundary: lw @0x10011FFC succeeds, err=0.
- req held high continuously over three loads -> each accepted the cycle after RESP; busy=1 between accept and ready; no request lost or duplicated.
- Mid-operation reset: assert reset=0 while in WR of sb 0xAA @0x10010004 -> outputs 0 immediately; after release, lw @0x10010004 returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and
// the default data-segment base used by the CPU-side address translation.
package dmem_pkg;

   localparam logic [31:0] DATA_SEG_BASE = 32'h1001_0000;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Illegal size encoding or an access not aligned to its own size.
   function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] off_lo);
      return (size == 2'd3) ||
             ((size == SZ_HALF) && off_lo[0]) ||
             ((size == SZ_WORD) && (off_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU <-> data-memory handshake bundle; the CPU is the master, the memory the slave.
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (output req, we, size, sext, addr, wdata,
                   input  rdata, ready, err, busy);
   modport slave  (input  req, we, size, sext, addr, wdata,
                   output rdata, ready, err, busy);
endinterface

// File: rtl/dmem_responder_lane.sv
// Little-endian lane logic: load extraction with sign/zero extension and
// sub-word store merging into an existing word.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off_lo,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      byte_val  = word[{off_lo, 3'b000} +: 8];
      half_val  = off_lo[1] ? word[31:16] : word[15:0];
      load_data = word;
      if (size == SZ_BYTE)
         load_data = {{24{sext & byte_val[7]}}, byte_val};
      else if (size == SZ_HALF)
         load_data = {{16{sext & half_val[15]}}, half_val};
   end

   // Each byte lane independently chooses store data or the old word's byte.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = gi[1:0];
         logic       sel;
         logic [7:0] src;

         always_comb begin
            sel = 1'b1;
            src = wdata[8*gi +: 8];
            if (size == SZ_BYTE) begin
               sel = (off_lo == LANE);
               src = wdata[7:0];
            end else if (size == SZ_HALF) begin
               sel = (off_lo[1] == LANE[1]);
               src = LANE[0] ? wdata[15:8] : wdata[7:0];
            end
         end

         assign store_word[8*gi +: 8] = sel ? src : word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, word array with registered
// read, sub-word stores done as read-modify-write.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DATA_SEG_BASE,
   parameter int          ADDR_WIDTH = 11
)(
   input  logic             clk_in,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [31:0]           mem_q;

   logic [1:0]            state_reg;
   logic                  we_reg;
   logic [1:0]            size_reg;
   logic                  sext_reg;
   logic [31:0]           wdata_reg;
   logic [1:0]            off_lo_reg;
   logic [ADDR_WIDTH-1:0] idx_reg;
   logic [31:0]           rdata_reg;
   logic                  ready_reg;
   logic                  err_reg;
   logic                  busy_reg;

   logic [31:0]           off_c;
   logic                  req_err;
   logic                  accept;
   logic [31:0]           load_data;
   logic [31:0]           store_word;

   // Addresses below the base wrap to a huge offset and fall out of range.
   assign off_c   = bus.addr - BASE_ADDR;
   assign req_err = (|off_c[31:ADDR_WIDTH+2]) || access_misaligned(bus.size, off_c[1:0]);
   assign accept  = (state_reg == ST_IDLE) && bus.req;

   dmem_lane u_lane (
      .word       (mem_q),
      .off_lo     (off_lo_reg),
      .size       (size_reg),
      .sext       (sext_reg),
      .wdata      (wdata_reg),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // The read is launched on the accept edge so the word is ready during RD.
   always_ff @(posedge clk_in) begin
      if (accept && !req_err)
         mem_q <= mem[off_c[ADDR_WIDTH+1:2]];
      if (state_reg == ST_WR)
         mem[idx_reg] <= store_word;
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         we_reg     <= 1'b0;
         size_reg   <= SZ_BYTE;
         sext_reg   <= 1'b0;
         wdata_reg  <= '0;
         off_lo_reg <= '0;
         idx_reg    <= '0;
         rdata_reg  <= '0;
         ready_reg  <= 1'b0;
         err_reg    <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req) begin
                  we_reg     <= bus.we;
                  size_reg   <= bus.size;
                  sext_reg   <= bus.sext;
                  wdata_reg  <= bus.wdata;
                  off_lo_reg <= off_c[1:0];
                  idx_reg    <= off_c[ADDR_WIDTH+1:2];
                  busy_reg   <= 1'b1;
                  if (req_err) begin
                     ready_reg <= 1'b1;
                     err_reg   <= 1'b1;
                     rdata_reg <= '0;
                     state_reg <= ST_RESP;
                  end else if (bus.we && (bus.size == SZ_WORD)) begin
                     state_reg <= ST_WR;
                  end else begin
                     state_reg <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (we_reg) begin
                  state_reg <= ST_WR;
               end else begin
                  rdata_reg <= load_data;
                  ready_reg <= 1'b1;
                  state_reg <= ST_RESP;
               end
            end
            ST_WR: begin
               ready_reg <= 1'b1;
               state_reg <= ST_RESP;
            end
            default: begin
               ready_reg <= 1'b0;
               err_reg   <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rdata = rdata_reg;
   assign bus.ready = ready_reg;
   assign bus.err   = err_reg;
   assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, lane extraction/merging, error
// responses, back-to-back requests and reset during a store.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk_in;
   logic reset;
   int   total;
   int   passed;

   dmem_responder_if bus ();

   dmem_responder dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One request; latency counts the accept edge as edge 1.
   task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                            input logic s, input logic [31:0] a, input logic [31:0] d,
                            input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
      int lat;
      int busy_drop;
      @(negedge clk_in);
      bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sext = s; bus.addr = a; bus.wdata = d;
      @(posedge clk_in); #1;
      bus.req = 1'b0; bus.we = ~w; bus.size = 2'd3; bus.addr = $urandom; bus.wdata = $urandom;
      lat = 1;
      busy_drop = 0;
      while (!bus.ready && lat < 8) begin
         if (!bus.busy) busy_drop++;
         @(posedge clk_in); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      chk({tag, "_busydrop"}, 32'(busy_drop), 32'd0);
      chk({tag, "_err"}, {31'b0, bus.err}, {31'b0, exp_err});
      chk({tag, "_rdata"}, bus.rdata, exp_rdata);
      $display("txn %s addr=%h lat=%0d err=%0b rdata=%h", tag, a, lat, bus.err, bus.rdata);
      @(posedge clk_in); #1;
      chk({tag, "_pulse"}, {30'b0, bus.ready, bus.busy}, 32'd0);
   endtask

   logic [31:0] haddr [3];
   logic [31:0] hexp  [3];

   initial begin
      int cyc;
      int lat;
      int busy_drop;
      int extra;
      total = 0; passed = 0;
      haddr[0] = 32'h1001_0004; haddr[1] = 32'h1001_1FFC; haddr[2] = 32'h1001_0004;
      hexp[0]  = 32'h8001_80EF; hexp[1]  = 32'h1234_5678; hexp[2]  = 32'h8001_80EF;

      reset = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.sext = 1'b0;
      bus.addr = '0; bus.wdata = '0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_ready", {31'b0, bus.ready}, 32'd0);
      chk("rst_err",   {31'b0, bus.err},   32'd0);
      chk("rst_busy",  {31'b0, bus.busy},  32'd0);
      @(negedge clk_in);
      reset = 1'b1;

      do_access("sw",   1'b1, SZ_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
      do_access("lw",   1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
      do_access("sb",   1'b1, SZ_BYTE, 1'b0, 32'h1001_0005, 32'h0000_0080, 3, 1'b0, 32'hDEAD_BEEF);
      do_access("lb",   1'b0, SZ_BYTE, 1'b1, 32'h1001_0005, 32'h0, 2, 1'b0, 32'hFFFF_FF80);
      do_access("lbu",  1'b0, SZ_BYTE, 1'b0, 32'h1001_0005, 32'h0, 2, 1'b0, 32'h0000_0080);
      do_access("lw_b", 1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 2, 1'b0, 32'hDEAD_80EF);
      do_access("sh",   1'b1, SZ_HALF, 1'b0, 32'h1001_0006, 32'h0000_8001, 3, 1'b0, 32'hDEAD_80EF);
      do_access("lw_h", 1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 2, 1'b0, 32'h8001_80EF);
      do_access("lh",   1'b0, SZ_HALF, 1'b1, 32'h1001_0006, 32'h0, 2, 1'b0, 32'hFFFF_8001);
      do_access("lhu",  1'b0, SZ_HALF, 1'b0, 32'h1001_0006, 32'h0, 2, 1'b0, 32'h0000_8001);

      do_access("e_lw_mis", 1'b0, SZ_WORD, 1'b0, 32'h1001_0002, 32'h0, 1, 1'b1, 32'h0);
      do_access("e_lh_mis", 1'b0, SZ_HALF, 1'b0, 32'h1001_0001, 32'h0, 1, 1'b1, 32'h0);
      do_access("e_size3",  1'b1, 2'd3,    1'b0, 32'h1001_0004, 32'h0, 1, 1'b1, 32'h0);
      do_access("e_high",   1'b0, SZ_WORD, 1'b0, 32'h1001_2000, 32'h0, 1, 1'b1, 32'h0);
      do_access("e_low",    1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0, 1, 1'b1, 32'h0);
      do_access("lw_post",  1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 2, 1'b0, 32'h8001_80EF);

      do_access("sw_top", 1'b1, SZ_WORD, 1'b0, 32'h1001_1FFC, 32'h1234_5678, 2, 1'b0, 32'h8001_80EF);
      do_access("lw_top", 1'b0, SZ_WORD, 1'b0, 32'h1001_1FFC, 32'h0, 2, 1'b0, 32'h1234_5678);

      // req held high across three loads
      @(negedge clk_in);
      bus.req = 1'b1; bus.we = 1'b0; bus.size = SZ_WORD; bus.sext = 1'b0; bus.addr = haddr[0];
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         do begin
            @(posedge clk_in); #1;
            cyc++;
         end while (!bus.busy && cyc < 10);
         chk("held_accept", {31'b0, bus.busy}, 32'd1);
         chk("held_gap", 32'(cyc), (k == 0) ? 32'd1 : 32'd2);
         if (k < 2) bus.addr = haddr[k+1];
         else bus.req = 1'b0;
         lat = 1;
         busy_drop = 0;
         while (!bus.ready && lat < 8) begin
            if (!bus.busy) busy_drop++;
            @(posedge clk_in); #1;
            lat++;
         end
         chk("held_lat", 32'(lat), 32'd2);
         chk("held_busydrop", 32'(busy_drop), 32'd0);
         chk("held_err", {31'b0, bus.err}, 32'd0);
         chk("held_rdata", bus.rdata, hexp[k]);
         $display("txn held%0d addr=%h lat=%0d rdata=%h", k, haddr[k], lat, bus.rdata);
      end
      extra = 0;
      repeat (6) begin
         @(posedge clk_in); #1;
         if (bus.ready) extra++;
      end
      chk("held_extra", 32'(extra), 32'd0);

      // reset while the sub-word store sits in WR
      @(negedge clk_in);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = SZ_BYTE; bus.sext = 1'b0;
      bus.addr = 32'h1001_0004; bus.wdata = 32'h0000_00AA;
      @(posedge clk_in); #1;
      bus.req = 1'b0;
      @(posedge clk_in); #1;
      chk("mid_busy", {31'b0, bus.busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rdata", bus.rdata, 32'h0);
      chk("mid_ready", {31'b0, bus.ready}, 32'd0);
      chk("mid_err",   {31'b0, bus.err},   32'd0);
      chk("mid_busy0", {31'b0, bus.busy},  32'd0);
      $display("txn midreset sb addr=10010004 aborted");
      @(negedge clk_in);
      reset = 1'b1;
      do_access("lw_mid", 1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 2, 1'b0, 32'h8001_80EF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
